// File: rtl/gate_pkg.sv
// Shared definitions for the gate truth-table scanner: op encodings, FSM state, gate evaluation.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam int unsigned MAX_IN = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reduction gate over the low n bits of vec; reserved ops give 0.
    function automatic logic gate_eval(input logic [2:0] op, input logic [7:0] vec,
                                       input int unsigned n);
        logic [7:0] mask;
        logic       r_and;
        logic       r_or;
        logic       r_xor;
        mask  = 8'((16'd1 << n) - 16'd1);
        r_and = &(vec | ~mask);
        r_or  = |(vec & mask);
        r_xor = ^(vec & mask);
        case (op)
            OP_AND:  gate_eval = r_and;
            OP_OR:   gate_eval = r_or;
            OP_XOR:  gate_eval = r_xor;
            OP_NAND: gate_eval = ~r_and;
            OP_NOR:  gate_eval = ~r_or;
            OP_XNOR: gate_eval = ~r_xor;
            default: gate_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_eval_unit.sv
// Purely combinational N_IN-input gate, operation selected by op.
module gate_eval_unit
    import gate_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] vec,
    output logic            y
);

    always_comb begin
        y = gate_eval(op, 8'(vec), N_IN);
    end

endmodule

// File: rtl/gate_truth_scanner.sv
// Walks an N_IN-bit vector through all combinations, holding each HOLD_CYCLES cycles,
// and captures the gate truth table plus its ones-count.
module gate_truth_scanner
    import gate_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    output logic                  busy,
    output logic                  vec_valid,
    output logic [N_IN-1:0]       vec,
    output logic                  y,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic [N_IN:0]         ones_count
);

    localparam int unsigned TW = 1 << N_IN;
    localparam int unsigned IW = N_IN + 1;
    localparam int unsigned CW = N_IN + 1;
    localparam int unsigned HW = 8;

    state_t          state;
    logic [2:0]      op_q;
    logic [IW-1:0]   idx;
    logic [HW-1:0]   hold_cnt;
    logic            eval_y;
    logic            last_hold;
    logic            last_idx;

    // idx runs past the last combination to 2^N_IN, whose low bits park vec at 0.
    assign vec       = idx[N_IN-1:0];
    assign y         = vec_valid & eval_y;
    assign last_hold = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_idx  = (idx == IW'(TW - 1));

    gate_eval_unit #(.N_IN(N_IN)) u_eval (
        .op  (op_q),
        .vec (vec),
        .y   (eval_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            vec_valid  <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
            op_q       <= '0;
            idx        <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_RUN;
                        op_q       <= op;
                        idx        <= '0;
                        hold_cnt   <= '0;
                        table_out  <= '0;
                        ones_count <= '0;
                        busy       <= 1'b1;
                        vec_valid  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_hold) begin
                        hold_cnt                  <= '0;
                        table_out[idx[N_IN-1:0]]  <= y;
                        ones_count                <= ones_count + CW'(y);
                        idx                       <= idx + IW'(1);
                        if (last_idx) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            vec_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Directed bench for gate_truth_scanner over four parameter sets sharing clock and reset.
module tb_gate_truth_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: N=2 H=1, b: N=3 H=1, c: N=2 H=3, d: N=1 H=1
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
    logic [2:0] op_a = 3'd0, op_b = 3'd0, op_c = 3'd0, op_d = 3'd0;

    logic busy_a, vv_a, y_a, done_a;
    logic [1:0] vec_a; logic [3:0] tab_a; logic [2:0] cnt_a;
    logic busy_b, vv_b, y_b, done_b;
    logic [2:0] vec_b; logic [7:0] tab_b; logic [3:0] cnt_b;
    logic busy_c, vv_c, y_c, done_c;
    logic [1:0] vec_c; logic [3:0] tab_c; logic [2:0] cnt_c;
    logic busy_d, vv_d, y_d, done_d;
    logic [0:0] vec_d; logic [1:0] tab_d; logic [1:0] cnt_d;

    gate_truth_scanner #(.N_IN(2), .HOLD_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .busy(busy_a),
        .vec_valid(vv_a), .vec(vec_a), .y(y_a), .done(done_a),
        .table_out(tab_a), .ones_count(cnt_a));
    gate_truth_scanner #(.N_IN(3), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .busy(busy_b),
        .vec_valid(vv_b), .vec(vec_b), .y(y_b), .done(done_b),
        .table_out(tab_b), .ones_count(cnt_b));
    gate_truth_scanner #(.N_IN(2), .HOLD_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c), .busy(busy_c),
        .vec_valid(vv_c), .vec(vec_c), .y(y_c), .done(done_c),
        .table_out(tab_c), .ones_count(cnt_c));
    gate_truth_scanner #(.N_IN(1), .HOLD_CYCLES(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .op(op_d), .busy(busy_d),
        .vec_valid(vv_d), .vec(vec_d), .y(y_d), .done(done_d),
        .table_out(tab_d), .ones_count(cnt_d));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int done_seen;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_vv", 32'(vv_a), 32'd0);
        check("rst_y_nand_idle", 32'({y_a, y_b, y_c, y_d}), 32'd0);
        check("rst_tab", 32'({tab_a, tab_b, tab_c, tab_d}), 32'd0);
        check("rst_cnt", 32'({cnt_a, cnt_b, cnt_c, cnt_d}), 32'd0);
        rst_n = 1'b1;
        tick();

        // AND at N=2: vec 0..3 then done at t+5
        start_a = 1'b1; op_a = 3'd0;
        tick(); start_a = 1'b0;
        check("and_busy", 32'(busy_a), 32'd1);
        check("and_vv", 32'(vv_a), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("and_vec", 32'(vec_a), 32'(k));
            check("and_y", 32'(y_a), (k == 3) ? 32'd1 : 32'd0);
            check("and_nodone", 32'(done_a), 32'd0);
            tick();
        end
        check("and_done", 32'(done_a), 32'd1);
        check("and_busy_done", 32'(busy_a), 32'd0);
        check("and_vv_done", 32'(vv_a), 32'd0);
        check("and_tab", 32'(tab_a), 32'h8);
        check("and_cnt", 32'(cnt_a), 32'd1);
        tick();
        check("and_done_pulse", 32'(done_a), 32'd0);
        check("and_tab_hold", 32'(tab_a), 32'h8);

        // XOR then XNOR at N=3
        start_b = 1'b1; op_b = 3'd2;
        tick(); start_b = 1'b0;
        for (int i = 0; i < 50 && !done_b; i++) tick();
        check("xor_done", 32'(done_b), 32'd1);
        check("xor_tab", 32'(tab_b), 32'h96);
        check("xor_cnt", 32'(cnt_b), 32'd4);
        tick();
        start_b = 1'b1; op_b = 3'd5;
        tick(); start_b = 1'b0;
        for (int i = 0; i < 50 && !done_b; i++) tick();
        check("xnor_done", 32'(done_b), 32'd1);
        check("xnor_tab", 32'(tab_b), 32'h69);
        check("xnor_cnt", 32'(cnt_b), 32'd4);
        tick();

        // NOR at N=2 with 3-cycle hold: done at t+13
        start_c = 1'b1; op_c = 3'd4;
        tick(); start_c = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("nor_vec", 32'(vec_c), 32'(k / 3));
            check("nor_y", 32'(y_c), (k < 3) ? 32'd1 : 32'd0);
            check("nor_nodone", 32'(done_c), 32'd0);
            tick();
        end
        check("nor_done", 32'(done_c), 32'd1);
        check("nor_tab", 32'(tab_c), 32'h1);
        check("nor_cnt", 32'(cnt_c), 32'd1);
        tick();

        // Mid-scan start/op interference, then start in the done cycle
        start_a = 1'b1; op_a = 3'd0;
        tick(); start_a = 1'b0;
        tick();
        start_a = 1'b1; op_a = 3'd1;
        tick(); start_a = 1'b0;
        check("intf_vec", 32'(vec_a), 32'd2);
        check("intf_y_orig_op", 32'(y_a), 32'd0);
        for (int i = 0; i < 20 && !done_a; i++) tick();
        check("intf_done", 32'(done_a), 32'd1);
        check("intf_tab", 32'(tab_a), 32'h8);
        check("intf_cnt", 32'(cnt_a), 32'd1);
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        check("dstart_busy0", 32'(busy_a), 32'd0);
        tick();
        check("dstart_busy1", 32'(busy_a), 32'd0);
        check("dstart_vv", 32'(vv_a), 32'd0);

        // Reset abort at idx=2
        start_a = 1'b1; op_a = 3'd3;
        tick(); start_a = 1'b0;
        tick(); tick();
        check("abort_idx2", 32'(vec_a), 32'd2);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_vv", 32'(vv_a), 32'd0);
        check("abort_vec_y", 32'({vec_a, y_a}), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_tab_cnt", 32'({tab_a, cnt_a}), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_a) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        start_a = 1'b1; op_a = 3'd1;
        tick(); start_a = 1'b0;
        check("fresh_vec0", 32'(vec_a), 32'd0);
        check("fresh_vv", 32'(vv_a), 32'd1);
        for (int i = 0; i < 20 && !done_a; i++) tick();
        check("fresh_done", 32'(done_a), 32'd1);
        check("fresh_tab", 32'(tab_a), 32'he);
        check("fresh_cnt", 32'(cnt_a), 32'd3);
        tick();

        // Reserved op
        start_b = 1'b1; op_b = 3'd6;
        tick(); start_b = 1'b0;
        check("rsv_y", 32'(y_b), 32'd0);
        for (int i = 0; i < 50 && !done_b; i++) tick();
        check("rsv_done", 32'(done_b), 32'd1);
        check("rsv_tab", 32'(tab_b), 32'h0);
        check("rsv_cnt", 32'(cnt_b), 32'd0);
        tick();

        // Back-to-back OR then NAND at N=1
        start_d = 1'b1; op_d = 3'd1;
        tick(); start_d = 1'b0;
        check("b2b_or_v0", 32'({vec_d, y_d}), 32'b00);
        tick();
        check("b2b_or_v1", 32'({vec_d, y_d}), 32'b11);
        tick();
        check("b2b_or_done", 32'(done_d), 32'd1);
        check("b2b_or_tab", 32'(tab_d), 32'b10);
        check("b2b_or_cnt", 32'(cnt_d), 32'd1);
        tick();
        start_d = 1'b1; op_d = 3'd3;
        tick(); start_d = 1'b0;
        check("b2b_nand_busy", 32'(busy_d), 32'd1);
        check("b2b_nand_tab_clr", 32'(tab_d), 32'd0);
        for (int i = 0; i < 20 && !done_d; i++) tick();
        check("b2b_nand_done", 32'(done_d), 32'd1);
        check("b2b_nand_tab", 32'(tab_d), 32'b01);
        check("b2b_nand_cnt", 32'(cnt_d), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
